// File: rtl/priority_arbiter_8_pkg.sv
// -----------------------------------------------------------------------------
// priority_arbiter_8_pkg
//   Shared definitions for the 8-requester priority arbiter:
//     - requester count and grant-index width
//     - FSM state encoding (IDLE / GRANT)
//     - the search start used for fixed priority (requester 7 searched first)
//     - helper turning a grant index into a one-hot vector
//   No ports; imported by priority_arbiter_8 and arb_pick8.
// -----------------------------------------------------------------------------
package priority_arbiter_8_pkg;

    localparam int ARB_NREQ = 8;
    localparam int ARB_ID_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Fixed priority is round-robin search that always starts at index 7.
    localparam logic [ARB_ID_W-1:0] ARB_FIXED_START = 3'd7;

    // Pointer value after reset: the first round-robin search starts at 7.
    localparam logic [ARB_ID_W-1:0] ARB_PTR_RESET = 3'd7;

    function automatic logic [ARB_NREQ-1:0] id_to_onehot(input logic [ARB_ID_W-1:0] id);
        return ARB_NREQ'(1) << id;
    endfunction

endpackage

// File: rtl/priority_arbiter_8_pick.sv
// -----------------------------------------------------------------------------
// arb_pick8
//   Combinational winner picker. Searches req downward starting at index
//   'start', wrapping 0 -> 7, and returns the first set index.
//   Implementation: rotate req so that 'start' lands on bit 7, priority-encode
//   with bit 7 highest, then rotate the found position back.
//   Ports:
//     req   in  [7:0]  request vector
//     start in  [2:0]  index searched first
//     id    out [2:0]  winning index (meaningless when valid=0)
//     valid out        at least one request is set
// -----------------------------------------------------------------------------
module arb_pick8
    import priority_arbiter_8_pkg::*;
(
    input  logic [ARB_NREQ-1:0] req,
    input  logic [ARB_ID_W-1:0] start,
    output logic [ARB_ID_W-1:0] id,
    output logic                valid
);

    logic [ARB_NREQ-1:0] rot;
    logic [ARB_ID_W-1:0] rot_pos;

    // rot[7] = req[start], rot[6] = req[start-1], ... i.e.
    // rot[i] = req[(start + i + 1) mod 8]. The 3-bit add does the wrap.
    genvar gi;
    generate
        for (gi = 0; gi < ARB_NREQ; gi++) begin : g_rot
            localparam logic [ARB_ID_W-1:0] OFS = ARB_ID_W'(gi + 1);
            logic [ARB_ID_W-1:0] src;
            assign src     = start + OFS;
            assign rot[gi] = req[src];
        end
    endgenerate

    always_comb begin
        rot_pos = '0;
        valid   = 1'b1;
        priority casez (rot)
            8'b1???????: rot_pos = 3'd7;
            8'b01??????: rot_pos = 3'd6;
            8'b001?????: rot_pos = 3'd5;
            8'b0001????: rot_pos = 3'd4;
            8'b00001???: rot_pos = 3'd3;
            8'b000001??: rot_pos = 3'd2;
            8'b0000001?: rot_pos = 3'd1;
            8'b00000001: rot_pos = 3'd0;
            default:     valid   = 1'b0;
        endcase
    end

    // Undo the rotation: position p in rot came from req[(start + p + 1) mod 8].
    assign id = rot_pos + start + 3'd1;

endmodule

// File: rtl/priority_arbiter_8.sv
// -----------------------------------------------------------------------------
// priority_arbiter_8
//   Sequential arbiter for one shared resource among 8 requesters.
//   In IDLE it picks a winner (fixed priority, 7 highest, or round-robin from
//   rr_ptr) and registers a one-hot grant. In GRANT it holds the grant while
//   the winner keeps requesting, for at most MAX_HOLD cycles; a forced release
//   raises a one-cycle timeout pulse. Each release is followed by exactly one
//   idle cycle in which the next winner is chosen.
//   Parameters:
//     MAX_HOLD  max consecutive grant cycles per tenure (0 = unlimited)
//     CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//   Ports:
//     clk      in       rising-edge clock
//     rst      in       synchronous active-high reset
//     req      in  [7:0] request vector
//     mode_rr  in       0 = fixed priority, 1 = round-robin (sampled in IDLE)
//     gnt      out [7:0] registered one-hot grant, zero when idle
//     gnt_id   out [2:0] granted index, qualify with busy
//     busy     out      grant active
//     timeout  out      one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module priority_arbiter_8
    import priority_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ARB_NREQ-1:0] req,
    input  logic                mode_rr,
    output logic [ARB_NREQ-1:0] gnt,
    output logic [ARB_ID_W-1:0] gnt_id,
    output logic                busy,
    output logic                timeout
);

    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
    // Last counter value of a tenure; unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t          state_reg;
    logic [ARB_NREQ-1:0] gnt_reg;
    logic [ARB_ID_W-1:0] gnt_id_reg;
    logic                busy_reg;
    logic                timeout_reg;
    logic [CNT_W-1:0]    hold_cnt_reg;
    logic [ARB_ID_W-1:0] rr_ptr_reg;

    logic [ARB_ID_W-1:0] pick_start;
    logic [ARB_ID_W-1:0] pick_id;
    logic                pick_valid;
    logic                holder_req;
    logic                hold_expired;

    // Fixed priority is the same downward search pinned to start at 7.
    assign pick_start = mode_rr ? rr_ptr_reg : ARB_FIXED_START;

    arb_pick8 u_pick (
        .req   (req),
        .start (pick_start),
        .id    (pick_id),
        .valid (pick_valid)
    );

    assign holder_req   = req[gnt_id_reg];
    assign hold_expired = TIMEOUT_EN && (hold_cnt_reg == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            hold_cnt_reg <= '0;
            rr_ptr_reg   <= ARB_PTR_RESET;
        end else begin
            // timeout is a pulse: cleared every cycle unless set below.
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg    <= ST_GRANT;
                        gnt_reg      <= id_to_onehot(pick_id);
                        gnt_id_reg   <= pick_id;
                        busy_reg     <= 1'b1;
                        hold_cnt_reg <= '0;
                        // Pointer moves past the winner in both modes so a
                        // later switch to round-robin starts from a known place.
                        rr_ptr_reg   <= pick_id - 3'd1;
                    end
                end
                ST_GRANT: begin
                    if (!holder_req) begin
                        state_reg <= ST_IDLE;
                        gnt_reg   <= '0;
                        busy_reg  <= 1'b0;
                    end else if (hold_expired) begin
                        state_reg   <= ST_IDLE;
                        gnt_reg     <= '0;
                        busy_reg    <= 1'b0;
                        timeout_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // gnt_id keeps its last value in IDLE; consumers qualify it with busy.
    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_priority_arbiter_8.sv
module tb_priority_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       mode_rr = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic       m_st   = 1'b0;
    logic [7:0] m_gnt  = 8'h00;
    logic [2:0] m_id   = 3'd0;
    int         m_hold = 0;
    logic [2:0] m_ptr  = 3'd7;
    logic       m_to   = 1'b0;

    priority_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode_rr (mode_rr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [7:0] r, input logic m, input logic rs);
        logic [2:0] s;
        logic [2:0] idx;
        logic       found;
        m_to = 1'b0;
        if (rs) begin
            m_st = 1'b0; m_gnt = 8'h00; m_id = 3'd0; m_hold = 0; m_ptr = 3'd7;
        end else if (!m_st) begin
            if (r != 8'h00) begin
                s = m ? m_ptr : 3'd7;
                found = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    idx = s - 3'(j);
                    if (!found && r[idx]) begin
                        found = 1'b1;
                        m_id  = idx;
                    end
                end
                m_gnt  = 8'h00;
                m_gnt[m_id] = 1'b1;
                m_hold = 0;
                m_ptr  = m_id - 3'd1;
                m_st   = 1'b1;
            end
        end else if (!r[m_id]) begin
            m_gnt = 8'h00; m_st = 1'b0;
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1) begin
            m_gnt = 8'h00; m_st = 1'b0; m_to = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    // One clock of stimulus: drive, predict, wait the edge, compare.
    task automatic drive(input logic [7:0] r, input logic m, input logic rs);
        exp_t e;
        exp_t o;
        req = r; mode_rr = m; rst = rs;
        model_step(r, m, rs);
        e.gnt = m_gnt; e.id = m_id; e.busy = m_st; e.to = m_to;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        check("sb_gnt", 32'(gnt), 32'(o.gnt));
        check("sb_busy", 32'(busy), 32'(o.busy));
        check("sb_timeout", 32'(timeout), 32'(o.to));
        if (o.busy) check("sb_gnt_id", 32'(gnt_id), 32'(o.id));
        $display("t=%0t rst=%0b req=%02h rr=%0b -> gnt=%02h id=%0d busy=%0b to=%0b",
                 $time, rs, r, m, gnt, gnt_id, busy, timeout);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic [2:0] w;
        logic [7:0] ew;
        logic [7:0] rq;

        // 1. reset and idle
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h00, 1'b0, 1'b1);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive(8'h00, 1'b0, 1'b0);
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_timeout", 32'(timeout), 32'h0);
        end

        // 2. fixed priority, release then next winner
        drive(8'h24, 1'b0, 1'b0);
        check("fix_gnt5", 32'(gnt), 32'h20);
        check("fix_id5", 32'(gnt_id), 32'd5);
        drive(8'h04, 1'b0, 1'b0);
        check("fix_gap", 32'(gnt), 32'h0);
        drive(8'h04, 1'b0, 1'b0);
        check("fix_gnt2", 32'(gnt), 32'h04);
        check("fix_id2", 32'(gnt_id), 32'd2);
        drive(8'h00, 1'b0, 1'b0);
        check("fix_release", 32'(busy), 32'h0);

        // 3. round-robin rotation from a fresh pointer
        drive(8'hFF, 1'b1, 1'b1);
        for (int t = 0; t < 9; t++) begin
            w  = 3'(7 - t);
            ew = 8'h01 << w;
            drive(8'hFF, 1'b1, 1'b0);
            check("rr_gnt", 32'(gnt), 32'(ew));
            check("rr_id", 32'(gnt_id), 32'(w));
            drive(8'hFF, 1'b1, 1'b0);
            check("rr_hold", 32'(gnt), 32'(ew));
            rq = 8'hFF & ~ew;
            drive(rq, 1'b1, 1'b0);
            check("rr_gap", 32'(gnt), 32'h0);
        end

        // 4. hold timeout in fixed mode
        drive(8'h01, 1'b0, 1'b0);
        cnt = (gnt == 8'h01) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            if (gnt != 8'h01) break;
            drive(8'h01, 1'b0, 1'b0);
            if (gnt == 8'h01) cnt++;
        end
        check("to_tenure", 32'(cnt), 32'd16);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_gap", 32'(gnt), 32'h0);
        drive(8'h01, 1'b0, 1'b0);
        check("to_regrant", 32'(gnt), 32'h01);
        check("to_pulse_end", 32'(timeout), 32'h0);
        drive(8'h00, 1'b0, 1'b0);

        // 5. no preemption, mode change ignored mid-grant
        drive(8'h08, 1'b0, 1'b0);
        check("np_gnt3", 32'(gnt), 32'h08);
        for (int i = 0; i < 4; i++) begin
            drive(8'h88, 1'(i), 1'b0);
            check("np_hold", 32'(gnt), 32'h08);
        end
        drive(8'h80, 1'b1, 1'b0);
        check("np_gap", 32'(gnt), 32'h0);
        drive(8'h80, 1'b1, 1'b0);
        check("np_gnt7", 32'(gnt), 32'h80);
        check("np_id7", 32'(gnt_id), 32'd7);
        drive(8'h00, 1'b0, 1'b0);

        // 6. reset mid-grant restores pointer
        drive(8'h40, 1'b0, 1'b0);
        check("rg_gnt6", 32'(gnt), 32'h40);
        drive(8'h40, 1'b0, 1'b0);
        drive(8'h40, 1'b0, 1'b1);
        check("rg_gnt", 32'(gnt), 32'h0);
        check("rg_busy", 32'(busy), 32'h0);
        drive(8'hFF, 1'b1, 1'b0);
        check("rg_first", 32'(gnt), 32'h80);
        drive(8'h00, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
